// File: rtl/vga_frame_sched.sv
// vga_frame_sched: pixel divider, raster counters, line/frame strobes and blanking-window update arbiter
module vga_frame_sched #(
   parameter int CLK_DIV = 4,
   parameter int HD      = 640,
   parameter int HF      = 16,
   parameter int HR      = 96,
   parameter int HB      = 48,
   parameter int VD      = 480,
   parameter int VF      = 10,
   parameter int VR      = 2,
   parameter int VB      = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       line_start,
   output logic       frame_start,
   input  logic       upd_req,
   input  logic       upd_done,
   output logic       upd_grant,
   output logic       upd_overrun
);
   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;
   localparam int DW = $clog2(CLK_DIV);

   typedef enum logic [1:0] {IDLE, PENDING, GRANTED, RELEASE} state_t;

   state_t        state, nxt;
   logic [DW-1:0] div;
   logic          div_end, h_end, deadline, win, win_ok;

   assign div_end  = div == DW'(CLK_DIV - 1);
   assign h_end    = pix_tick && (h_count == 10'(HT - 1));
   // the pixel tick that would move v_count onto the guard line
   assign deadline = h_end && (v_count == 10'(VT - 2));
   assign win      = (v_count >= 10'(VD)) && (v_count <= 10'(VT - 2));
   // never grant on the deadline edge itself, or the grant would surface on the guard line
   assign win_ok   = win && !deadline;

   // clock divider producing a registered one-clk pixel enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div      <= '0;
         pix_tick <= 1'b0;
      end else begin
         div      <= div_end ? '0 : div + DW'(1);
         pix_tick <= div_end;
      end
   end

   // raster counters and strobes aligned with the first cycle of the wrapped values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_count     <= '0;
         v_count     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (pix_tick) begin
            h_count <= h_end ? '0 : h_count + 10'd1;
            if (h_end)
               v_count <= (v_count == 10'(VT - 1)) ? '0 : v_count + 10'd1;
         end
         line_start  <= h_end;
         frame_start <= h_end && (v_count == 10'(VT - 1));
      end
   end

   // arbiter state register and overrun pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         upd_overrun <= 1'b0;
      end else begin
         state       <= nxt;
         upd_overrun <= (state == GRANTED) && upd_req && !upd_done && deadline;
      end
   end

   // arbiter next state: done beats deadline, withdrawal aborts without overrun
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (upd_req) nxt = win_ok ? GRANTED : PENDING;
         PENDING: nxt = !upd_req ? IDLE : (win_ok ? GRANTED : PENDING);
         GRANTED: nxt = upd_done ? RELEASE : (!upd_req ? IDLE : (deadline ? RELEASE : GRANTED));
         RELEASE: if (!upd_req) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // arbiter outputs
   always_comb begin
      upd_grant = state == GRANTED;
   end
endmodule

// File: tb/tb_vga_frame_sched.sv
// tb_vga_frame_sched: randomized and directed checks of vga_frame_sched against a cycle-count reference model
module tb_vga_frame_sched;
   localparam int CLK_DIV = 3;
   localparam int HD = 8, HF = 2, HR = 3, HB = 2;
   localparam int VD = 6, VF = 2, VR = 1, VB = 2;
   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;
   localparam int LINE = HT * CLK_DIV;
   localparam int FRAME = HT * VT * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       upd_req = 1'b0;
   logic       upd_done = 1'b0;
   logic       pix_tick, line_start, frame_start, upd_grant, upd_overrun;
   logic [9:0] h_count, v_count;

   int errors = 0;
   int checks = 0;
   int c = 0;
   bit m_grant = 0, m_wait = 0, m_ovr = 0;

   vga_frame_sched #(.CLK_DIV(CLK_DIV), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
                     .VD(VD), .VF(VF), .VR(VR), .VB(VB)) dut (
      .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .h_count(h_count), .v_count(v_count),
      .line_start(line_start), .frame_start(frame_start), .upd_req(upd_req),
      .upd_done(upd_done), .upd_grant(upd_grant), .upd_overrun(upd_overrun));

   always #5 clk = ~clk;

   // c = rising edges since reset release; pixels consumed by counters follow from it
   function automatic int pcount(int cc);
      return cc == 0 ? 0 : (cc - 1) / CLK_DIV;
   endfunction
   function automatic bit exp_tick(int cc);
      return cc >= CLK_DIV && cc % CLK_DIV == 0;
   endfunction
   function automatic int exp_h(int cc);
      return pcount(cc) % HT;
   endfunction
   function automatic int exp_v(int cc);
      return (pcount(cc) / HT) % VT;
   endfunction
   function automatic bit exp_ls(int cc);
      return cc >= CLK_DIV + 1 && (cc - 1) % CLK_DIV == 0 && exp_h(cc) == 0;
   endfunction
   function automatic bit exp_fs(int cc);
      return exp_ls(cc) && exp_v(cc) == 0;
   endfunction
   function automatic logic [24:0] exp_vec();
      return {exp_tick(c), 10'(exp_h(c)), 10'(exp_v(c)), exp_ls(c), exp_fs(c), m_grant, m_ovr};
   endfunction

   // advance one clock; update model from inputs seen at the edge, then settle
   task automatic step();
      bit tk, w, dl;
      int h, v;
      tk = exp_tick(c); h = exp_h(c); v = exp_v(c);
      w = v >= VD && v <= VT - 2;
      dl = tk && h == HT - 1 && v == VT - 2;
      @(posedge clk);
      m_ovr = 0;
      if (!rst_n) begin
         c = 0; m_grant = 0; m_wait = 0;
      end else begin
         c++;
         if (m_grant) begin
            if (upd_done) begin m_grant = 0; m_wait = 1; end
            else if (!upd_req) m_grant = 0;
            else if (dl) begin m_grant = 0; m_wait = 1; m_ovr = 1; end
         end else if (m_wait) begin
            if (!upd_req) m_wait = 0;
         end else if (upd_req && w && !dl) m_grant = 1;
      end
      #1;
   endtask

   task automatic wait_v(input int target);
      int n = 0;
      while (v_count !== 10'(target) && n < 2 * FRAME) begin step(); n++; end
      checks++;
      if (v_count !== 10'(target)) begin
         errors++;
         $display("FAIL wait_v: v_count=%0d never reached %0d", v_count, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 0; upd_req = 0; upd_done = 0;
      repeat (5) step();
      checks++;
      if ({pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun} !== 25'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun});
      end
      rst_n = 1;
      for (int i = 1; i <= CLK_DIV + 1; i++) begin
         step();
         checks++;
         if (pix_tick !== (i == CLK_DIV)) begin
            errors++;
            $display("FAIL first_tick: clk %0d pix_tick=%b want %b", i, pix_tick, i == CLK_DIV);
         end
      end
      checks++;
      if (h_count !== 10'd1) begin
         errors++;
         $display("FAIL h_after_tick: got %0d want 1", h_count);
      end
   endtask

   task automatic test_raster();
      int last_ls = 1, last_fs = 1, max_h = 0, max_v = 0;
      for (int i = 0; i < 2 * FRAME + 10; i++) begin
         step();
         checks++;
         if ({pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun} !== exp_vec()) begin
            errors++;
            $display("FAIL raster: c=%0d got %h want %h", c, {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun}, exp_vec());
         end
         if (int'(h_count) > max_h) max_h = int'(h_count);
         if (int'(v_count) > max_v) max_v = int'(v_count);
         if (line_start) begin
            checks++;
            if (c - last_ls != LINE) begin
               errors++;
               $display("FAIL line_period: got %0d want %0d", c - last_ls, LINE);
            end
            last_ls = c;
         end
         if (frame_start) begin
            checks++;
            if (c - last_fs != FRAME || !line_start) begin
               errors++;
               $display("FAIL frame_period: got %0d want %0d ls=%b", c - last_fs, FRAME, line_start);
            end
            last_fs = c;
         end
      end
      checks++;
      if (max_h != HT - 1 || max_v != VT - 1) begin
         errors++;
         $display("FAIL raster_max: got h=%0d v=%0d want h=%0d v=%0d", max_h, max_v, HT - 1, VT - 1);
      end
   endtask

   task automatic test_pending();
      upd_req = 0;
      wait_v(1);
      upd_req = 1;
      wait_v(VD);
      checks++;
      if (upd_grant !== 1'b0) begin errors++; $display("FAIL pend_early: grant=%b want 0", upd_grant); end
      step();
      checks++;
      if (upd_grant !== 1'b1 || exp_vec() !== {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun}) begin
         errors++;
         $display("FAIL pend_grant: grant=%b want 1 (vec %h want %h)", upd_grant, {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun}, exp_vec());
      end
      upd_done = 1; step(); upd_done = 0;
      checks++;
      if (upd_grant !== 1'b0 || upd_overrun !== 1'b0) begin
         errors++;
         $display("FAIL pend_done: grant=%b ovr=%b want 0 0", upd_grant, upd_overrun);
      end
      step();
      checks++;
      if (upd_grant !== 1'b0) begin errors++; $display("FAIL pend_release_hold: grant=%b want 0", upd_grant); end
      upd_req = 0; step();
      upd_req = 1; step();
      checks++;
      if (upd_grant !== 1'b1 || v_count > 10'(VT - 2)) begin
         errors++;
         $display("FAIL pend_regrant: grant=%b v=%0d want 1 in window", upd_grant, v_count);
      end
   endtask

   task automatic test_overrun();
      int n = 0;
      upd_req = 0;
      wait_v(1);
      upd_req = 1;
      wait_v(VD);
      step();
      checks++;
      if (upd_grant !== 1'b1) begin errors++; $display("FAIL ovr_grant: grant=%b want 1", upd_grant); end
      while (upd_grant === 1'b1 && n < FRAME) begin
         step(); n++;
         checks++;
         if ({pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun} !== exp_vec()) begin
            errors++;
            $display("FAIL ovr_track: c=%0d got %h want %h", c, {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun}, exp_vec());
         end
      end
      checks++;
      if (upd_overrun !== 1'b1 || upd_grant !== 1'b0 || v_count !== 10'(VT - 1) || h_count !== 10'd0) begin
         errors++;
         $display("FAIL ovr_pulse: ovr=%b grant=%b v=%0d h=%0d want 1 0 %0d 0", upd_overrun, upd_grant, v_count, h_count, VT - 1);
      end
      step();
      checks++;
      if (upd_overrun !== 1'b0) begin errors++; $display("FAIL ovr_width: ovr=%b want 0", upd_overrun); end
      wait_v(VD);
      repeat (10) step();
      checks++;
      if (upd_grant !== 1'b0) begin errors++; $display("FAIL ovr_no_regrant: grant=%b want 0", upd_grant); end
      upd_req = 0; step();
      upd_req = 1; step();
      checks++;
      if (upd_grant !== 1'b1) begin errors++; $display("FAIL ovr_fresh_req: grant=%b want 1", upd_grant); end
   endtask

   task automatic test_abort();
      int n = 0;
      upd_req = 0; step();
      checks++;
      if (upd_grant !== 1'b0 || upd_overrun !== 1'b0) begin
         errors++;
         $display("FAIL abort: grant=%b ovr=%b want 0 0", upd_grant, upd_overrun);
      end
      upd_done = 1; step(); upd_done = 0; step();
      checks++;
      if (upd_grant !== 1'b0 || upd_overrun !== 1'b0) begin
         errors++;
         $display("FAIL idle_done: grant=%b ovr=%b want 0 0", upd_grant, upd_overrun);
      end
      upd_req = 1; step();
      checks++;
      if (upd_grant !== 1'b1) begin errors++; $display("FAIL idle_done_grant: grant=%b want 1", upd_grant); end
      while (!(pix_tick === 1'b1 && h_count === 10'(HT - 1) && v_count === 10'(VT - 2)) && n < FRAME) begin
         step(); n++;
      end
      checks++;
      if (upd_grant !== 1'b1) begin errors++; $display("FAIL dl_pre_grant: grant=%b want 1", upd_grant); end
      upd_done = 1; step(); upd_done = 0;
      checks++;
      if (upd_overrun !== 1'b0 || upd_grant !== 1'b0 || v_count !== 10'(VT - 1)) begin
         errors++;
         $display("FAIL done_at_deadline: ovr=%b grant=%b v=%0d want 0 0 %0d", upd_overrun, upd_grant, v_count, VT - 1);
      end
      upd_req = 0; step();
   endtask

   task automatic test_async_reset();
      int n = 0;
      upd_req = 1;
      wait_v(VD + 1);
      checks++;
      if (upd_grant !== 1'b1) begin errors++; $display("FAIL ar_pre_grant: grant=%b want 1", upd_grant); end
      #2 rst_n = 0;
      #1;
      checks++;
      if (upd_grant !== 1'b0 || h_count !== 10'd0 || v_count !== 10'd0 || pix_tick !== 1'b0) begin
         errors++;
         $display("FAIL ar_immediate: grant=%b h=%0d v=%0d tick=%b want all 0", upd_grant, h_count, v_count, pix_tick);
      end
      repeat (3) step();
      rst_n = 1;
      while (v_count !== 10'(VD) && n < 2 * FRAME) begin
         step(); n++;
         checks++;
         if (upd_grant !== 1'b0 || {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun} !== exp_vec()) begin
            errors++;
            $display("FAIL ar_no_grant: c=%0d got %h want %h", c, {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun}, exp_vec());
         end
      end
      step();
      checks++;
      if (upd_grant !== 1'b1) begin errors++; $display("FAIL ar_grant_at_vd: grant=%b want 1 v=%0d", upd_grant, v_count); end
      upd_req = 0; step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3 * FRAME; i++) begin
         if ($urandom_range(0, 19) == 0) upd_req = ~upd_req;
         upd_done = $urandom_range(0, 29) == 0;
         step();
         checks++;
         if ({pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun} !== exp_vec()) begin
            errors++;
            $display("FAIL random: c=%0d req=%b done=%b got %h want %h", c, upd_req, upd_done, {pix_tick, h_count, v_count, line_start, frame_start, upd_grant, upd_overrun}, exp_vec());
         end
         checks++;
         if (upd_grant === 1'b1 && (v_count < 10'(VD) || v_count == 10'(VT - 1))) begin
            errors++;
            $display("FAIL grant_outside_window: v=%0d", v_count);
         end
      end
      upd_done = 0;
   endtask

   initial begin
      test_reset();
      test_raster();
      test_pending();
      test_overrun();
      test_abort();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/vga_frame_sched.md
# vga_frame_sched

Timing controller for the VGA output path. It divides the system clock down to the pixel rate and generates the free-running `h_count`/`v_count` raster counters that feed the sync/blanking decode. It also provides line-start and frame-start strobes. It arbitrates a shared update window so that game logic can modify frame state only during vertical blanking, and it revokes access before active video resumes.

## Interface

Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz gives 25 MHz); legal range ≥2.
- `HD`, 640: horizontal display pixels.
- `HF`, 16: horizontal front porch.
- `HR`, 96: horizontal sync width.
- `HB`, 48: horizontal back porch.
- `VD`, 480: vertical display lines.
- `VF`, 10: vertical front porch.
- `VR`, 2: vertical sync width.
- `VB`, 33: vertical back porch.
- Derived values: `HT = HD+HF+HR+HB` (800) and `VT = VD+VF+VR+VB` (525).

Ports:
- `clk` in, 1: system clock. One clock domain only.
- `rst_n` in, 1: asynchronous, active-low reset.
- `pix_tick` out, 1: one-`clk` pixel enable.
- `h_count` out, 10: horizontal position, 0..HT-1.
- `v_count` out, 10: vertical position, 0..VT-1.
- `line_start` out, 1: one-`clk` pulse when `h_count` wraps to 0.
- `frame_start` out, 1: one-`clk` pulse when both counters wrap to 0.
- `upd_req` in, 1: level request from game logic for the update window.
- `upd_done` in, 1: one-`clk` pulse indicating the update is finished.
- `upd_grant` out, 1: level grant; the requester may write frame state only while this is high.
- `upd_overrun` out, 1: one-`clk` pulse when a grant is revoked at the deadline.

## Operation

- **Divider:** `div` counts 0..CLK_DIV-1 and wraps. `pix_tick` is registered and is high in the `clk` cycle after `div == CLK_DIV-1`.
- **Counters:** `h_count` and `v_count` update only on `pix_tick`.
  - `h_count` increments and wraps HT-1 → 0.
  - On that wrap, `v_count` increments and wraps VT-1 → 0.
  - All counter arithmetic is unsigned 10-bit; no value outside the stated range is ever produced.
- **Strobes:** `line_start` and `frame_start` are registered. They are high for exactly one `clk`, in the first cycle in which the new wrapped counter values are visible. `frame_start` implies `line_start`. Neither strobe fires on reset release.
- **Eligible window:** `win = (v_count >= VD) && (v_count <= VT-2)`. The last line, VT-1, is reserved as guard time.
- **Arbiter FSM:**
  - IDLE:
    - `upd_req && win` → GRANTED.
    - `upd_req && !win` → PENDING.
  - PENDING:
    - `upd_req` low → IDLE (request withdrawn).
    - `win` → GRANTED.
  - GRANTED (`upd_grant = 1`):
    - `upd_done` → RELEASE.
    - `upd_req` low without `upd_done` → IDLE (abort, no overrun).
    - Deadline (`pix_tick` moving `v_count` to VT-1) → RELEASE and pulse `upd_overrun`.
    - Deadline and `upd_done` in the same cycle: `upd_done` wins and there is no overrun.
  - RELEASE (`upd_grant = 0`): wait for `upd_req` low, then → IDLE. This is a 4-phase handshake; a new grant requires a fresh rising request.
- `upd_done` outside GRANTED is ignored.
- Multiple grants within one blanking interval are legal if the requester completes the 4-phase handshake each time.

## Timing

- **Reset values:** `div = 0`, `h_count = 0`, `v_count = 0`. All outputs are 0 (`pix_tick`, `line_start`, `frame_start`, `upd_grant`, `upd_overrun`). FSM is IDLE.
- **Reset mid-operation:**
  - Asserting `rst_n` low clears everything asynchronously, including an active grant.
  - After release, the first `pix_tick` occurs at the CLK_DIV-th rising edge.
- **Period:** line = HT·CLK_DIV = 3200 `clk`; frame = HT·VT·CLK_DIV = 1,680,000 `clk`.
- **Grant latency:** `upd_grant` rises in the `clk` after the edge at which IDLE or PENDING samples `upd_req && win`.
- **Grant release latency:**
  - `upd_grant` falls in the `clk` after `upd_done` is sampled.
  - On the deadline, `upd_grant` falls in the same cycle that `v_count` first shows VT-1, coincident with the `upd_overrun` pulse.
- **Guarantee:** `upd_grant` is never high while `v_count < VD` or `v_count == VT-1`.

## Test plan

- **Reset:** hold `rst_n` low 5 `clk`, release → all outputs 0, first `pix_tick` at `clk` 4, `h_count` = 1 after that tick.
- **Raster cadence:** run 2 frames → `line_start` every 3200 `clk`, `frame_start` every 1,680,000 `clk`, `h_count` max 799, `v_count` max 524, no reset-release strobe.
- **Pending request:** raise `upd_req` at `v_count` = 100 → `upd_grant` rises 1 `clk` after `v_count` becomes 480. Pulse `upd_done` → grant falls next `clk`. Drop `upd_req` → FSM IDLE. Re-raise `upd_req` → re-granted within the same blanking interval.
- **Overrun:** grant at `v_count` = 480, never pulse `upd_done` → grant falls and `upd_overrun` pulses for 1 `clk` exactly when `v_count` becomes 524. No re-grant until `upd_req` drops and rises again with `v_count` in 480..523.
- **Abort and ignored done:**
  - Drop `upd_req` while granted → grant falls next `clk`, no overrun.
  - `upd_done` pulsed in IDLE → no effect.
  - `upd_done` coincident with the deadline → no overrun.
- **Async reset mid-grant:** assert `rst_n` low while granted at `v_count` = 500 → `upd_grant` and counters clear immediately without waiting for a `clk` edge; `upd_req` held high afterwards → no grant until `v_count` reaches 480.
